// File: rtl/ram_dp_fifo_ctrl_pkg.sv
// ============================================================================
// Module   : ram_dp_fifo_ctrl_pkg
// Brief    : Shared constants and helpers for the dual-port-RAM FIFO controller
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_dp_fifo_ctrl_pkg;

  // Output buffer occupancy codes (head + skid entry)
  localparam logic [1:0] BUF_EMPTY = 2'd0;
  localparam logic [1:0] BUF_ONE   = 2'd1;
  localparam logic [1:0] BUF_TWO   = 2'd2;

  // A new RAM read may start only if the buffer can hold its return next cycle
  function automatic logic issue_ok(input logic [1:0] occ,
                                    input logic       inflight,
                                    input logic       pop);
    logic [2:0] committed;
    committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    return (committed < {1'b0, BUF_TWO});
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_dualport.sv
// ============================================================================
// Module   : ram_dualport
// Brief    : True dual-port RAM, one clock, registered (read-old) outputs
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_dualport #(
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int RAM_DATA_WIDTH = 8
) (
  input  logic                      in_clk,
  input  logic [RAM_ADDR_WIDTH-1:0] in_addr_a,
  input  logic [RAM_DATA_WIDTH-1:0] in_data_a,
  input  logic                      in_wr_a,
  output logic [RAM_DATA_WIDTH-1:0] out_data_a,
  input  logic [RAM_ADDR_WIDTH-1:0] in_addr_b,
  input  logic [RAM_DATA_WIDTH-1:0] in_data_b,
  input  logic                      in_wr_b,
  output logic [RAM_DATA_WIDTH-1:0] out_data_b
);

  localparam int RAM_DEPTH = 2 ** RAM_ADDR_WIDTH;

  logic [RAM_DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic [RAM_DATA_WIDTH-1:0] r_data_a;
  logic [RAM_DATA_WIDTH-1:0] r_data_b;

  // Both ports in one process so the array has a single driver
  always_ff @(posedge in_clk) begin
    if (in_wr_a) r_mem[in_addr_a] <= in_data_a;
    if (in_wr_b) r_mem[in_addr_b] <= in_data_b;
    r_data_a <= r_mem[in_addr_a];
    r_data_b <= r_mem[in_addr_b];
  end

  assign out_data_a = r_data_a;
  assign out_data_b = r_data_b;

endmodule

`default_nettype wire

// File: rtl/ram_dp_fifo_ctrl.sv
// ============================================================================
// Module   : ram_dp_fifo_ctrl
// Brief    : FWFT FIFO over ram_dualport with a 2-entry output skid buffer
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_dp_fifo_ctrl
  import ram_dp_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  input  logic                  in_flush,
  input  logic                  in_wr_en,
  input  logic [DATA_WIDTH-1:0] in_wr_data,
  output logic                  out_full,
  output logic                  out_overflow,
  output logic                  out_rd_valid,
  input  logic                  in_rd_ready,
  output logic [DATA_WIDTH-1:0] out_rd_data,
  output logic                  out_empty,
  output logic [ADDR_WIDTH:0]   out_level
);

  localparam int                DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_ram_cnt;
  logic                  r_inflight;
  logic [1:0]            r_buf_occ;
  logic [DATA_WIDTH-1:0] r_buf_head;
  logic [DATA_WIDTH-1:0] r_buf_skid;
  logic [ADDR_WIDTH:0]   r_level;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_overflow;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic [ADDR_WIDTH:0]   w_level_nxt;
  logic [1:0]            w_occ_nxt;
  logic [DATA_WIDTH-1:0] w_head_nxt;
  logic [DATA_WIDTH-1:0] w_skid_nxt;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [DATA_WIDTH-1:0] w_unused_data_a;

  ram_dualport #(
    .RAM_ADDR_WIDTH (ADDR_WIDTH),
    .RAM_DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .in_clk     (in_clk),
    .in_addr_a  (r_wr_ptr),
    .in_data_a  (in_wr_data),
    .in_wr_a    (w_push),
    .out_data_a (w_unused_data_a),
    .in_addr_b  (r_rd_ptr),
    .in_data_b  ('0),
    .in_wr_b    (1'b0),
    .out_data_b (w_rd_data)
  );

  assign w_push  = in_wr_en & ~r_full;
  assign w_pop   = (r_buf_occ != BUF_EMPTY) & in_rd_ready;
  // r_ram_cnt only includes writes from earlier edges, so a word is never
  // read back on the edge that writes it
  assign w_issue = (r_ram_cnt != '0) & issue_ok(r_buf_occ, r_inflight, w_pop);

  assign w_level_nxt = r_level + (ADDR_WIDTH + 1)'(w_push) - (ADDR_WIDTH + 1)'(w_pop);

  // Pop shifts skid into head first; the returning read then lands in the
  // first free slot
  always_comb begin
    w_occ_nxt  = r_buf_occ;
    w_head_nxt = r_buf_head;
    w_skid_nxt = r_buf_skid;
    if (w_pop) begin
      w_head_nxt = r_buf_skid;
      w_occ_nxt  = r_buf_occ - 2'd1;
    end
    if (r_inflight) begin
      if (w_occ_nxt == BUF_EMPTY) w_head_nxt = w_rd_data;
      else                        w_skid_nxt = w_rd_data;
      w_occ_nxt = w_occ_nxt + BUF_ONE;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
      r_buf_occ  <= BUF_EMPTY;
      r_buf_head <= '0;
      r_buf_skid <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else if (in_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
      r_buf_occ  <= BUF_EMPTY;
      r_buf_head <= '0;
      r_buf_skid <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_issue) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      r_ram_cnt  <= r_ram_cnt + (ADDR_WIDTH + 1)'(w_push) - (ADDR_WIDTH + 1)'(w_issue);
      r_inflight <= w_issue;
      r_buf_occ  <= w_occ_nxt;
      r_buf_head <= w_head_nxt;
      r_buf_skid <= w_skid_nxt;
      r_level    <= w_level_nxt;
      r_full     <= (w_level_nxt == c_DEPTH);
      r_empty    <= (w_level_nxt == '0);
      if (in_wr_en && r_full) r_overflow <= 1'b1;
    end
  end

  assign out_full     = r_full;
  assign out_empty    = r_empty;
  assign out_overflow = r_overflow;
  assign out_level    = r_level;
  assign out_rd_valid = (r_buf_occ != BUF_EMPTY);
  assign out_rd_data  = r_buf_head;

endmodule

`default_nettype wire

// File: tb/tb_ram_dp_fifo_ctrl.sv
// ============================================================================
// Module   : tb_ram_dp_fifo_ctrl
// Brief    : Randomized/directed bench for ram_dp_fifo_ctrl against a queue model
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ram_dp_fifo_ctrl;

  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 2 ** AW;

  logic          sim_clk  = 1'b0;
  logic          rst_n    = 1'b0;
  logic          flush    = 1'b0;
  logic          wr_en    = 1'b0;
  logic [DW-1:0] wr_data  = '0;
  logic          rd_ready = 1'b0;
  logic          full;
  logic          overflow;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic [AW:0]   level;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] q[$];
  bit            m_ovf = 1'b0;
  int            stall = 0;
  int            n_pop = 0;

  ram_dp_fifo_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .in_clk       (sim_clk),
    .in_rst_n     (rst_n),
    .in_flush     (flush),
    .in_wr_en     (wr_en),
    .in_wr_data   (wr_data),
    .out_full     (full),
    .out_overflow (overflow),
    .out_rd_valid (rd_valid),
    .in_rd_ready  (rd_ready),
    .out_rd_data  (rd_data),
    .out_empty    (empty),
    .out_level    (level)
  );

  always #7.5 sim_clk = ~sim_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit we, input logic [DW-1:0] d, input bit rdy, input bit fl);
    wr_en    = we;
    wr_data  = d;
    rd_ready = rdy;
    flush    = fl;
  endtask

  // One clock: update the model for the coming edge, then check flags after it
  task automatic cycle();
    bit push_ok;
    @(negedge sim_clk);
    if (flush) begin
      q.delete();
      m_ovf = 1'b0;
      stall = 0;
    end else begin
      if (q.size() == 0)  check("valid_when_empty", rd_valid, 0);
      else if (stall >= 2) check("head_latency", rd_valid, 1);
      stall   = (q.size() > 0 && !rd_valid) ? stall + 1 : 0;
      push_ok = wr_en && (q.size() < DEPTH);
      if (wr_en && !push_ok) m_ovf = 1'b1;
      if (rd_valid && rd_ready && q.size() > 0) begin
        check("pop_data", rd_data, q[0]);
        void'(q.pop_front());
        n_pop++;
      end
      if (push_ok) q.push_back(wr_data);
    end
    @(posedge sim_clk);
    #1;
    check("level", level, q.size());
    check("full", full, q.size() == DEPTH);
    check("empty", empty, q.size() == 0);
    check("overflow", overflow, m_ovf);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #20;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    @(negedge sim_clk);
    rst_n = 1'b1;
    @(posedge sim_clk);
    #1;

    // Basic push with exact two-edge latency, then one pop
    drive(1, 8'hAA, 0, 0); cycle();
    drive(0, 8'h00, 0, 0); cycle();
    check("t1_valid_edge1", rd_valid, 0);
    cycle();
    check("t1_valid_edge2", rd_valid, 1);
    check("t1_data", rd_data, 8'hAA);
    check("t1_level", level, 1);
    drive(0, 8'h00, 1, 0); cycle();
    check("t1_empty_after_pop", empty, 1);
    check("t1_level_after_pop", level, 0);

    // Full / overflow, then drain in order
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'(i), 0, 0); cycle();
    end
    check("t2_full", full, 1);
    check("t2_level", level, 4);
    check("t2_overflow", overflow, 1);
    n_pop = 0;
    drive(0, 8'h00, 1, 0);
    repeat (8) cycle();
    check("t2_pop_count", n_pop, 4);

    // Streaming with pointer wrap, no bubbles once primed
    n_pop = 0;
    for (int k = 0; k < 768; k++) begin
      drive(1, 8'(k), 1, 0); cycle();
      check("t3_level_le3", level <= 3, 1);
      if (k >= 2) check("t3_no_bubble", rd_valid, 1);
    end
    drive(0, 8'h00, 1, 0);
    repeat (4) cycle();
    check("t3_pop_count", n_pop, 768);

    // Stall/skid: ready toggles every cycle at level >= 2
    drive(0, 8'h00, 0, 1); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'($urandom), 0, 0); cycle();
    end
    for (int i = 0; i < 40; i++) begin
      drive(q.size() < DEPTH, 8'($urandom), i[0], 0); cycle();
      check("t4_level_ge2", level >= 2, 1);
    end
    drive(0, 8'h00, 1, 0);
    repeat (8) cycle();

    // Simultaneous push and pop at level 1
    drive(1, 8'($urandom), 0, 0); cycle();
    drive(0, 8'h00, 0, 0); cycle(); cycle();
    for (int i = 0; i < 10; i++) begin
      check("t5_head_ready", rd_valid, 1);
      drive(1, 8'($urandom), 1, 0); cycle();
      check("t5_level", level, 1);
      check("t5_full", full, 0);
      check("t5_empty", empty, 0);
      drive(0, 8'h00, 0, 0); cycle(); cycle();
    end
    drive(0, 8'h00, 1, 0); cycle(); cycle();

    // Flush at level 3 with a read in flight
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'($urandom), 0, 0); cycle();
    end
    drive(0, 8'h00, 0, 0); cycle(); cycle();
    drive(0, 8'h00, 1, 0); cycle();
    check("t6_level_before_flush", level, 3);
    drive(0, 8'h00, 0, 1); cycle();
    check("t6_flush_level", level, 0);
    check("t6_flush_valid", rd_valid, 0);
    check("t6_flush_overflow", overflow, 0);
    drive(0, 8'h00, 0, 0); cycle(); cycle();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'($urandom), 1, 0); cycle();
    end
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", rd_valid, 0);
    check("t6_rst_level", level, 0);
    check("t6_rst_empty", empty, 1);
    check("t6_rst_data", rd_data, 0);
    q.delete();
    m_ovf = 1'b0;
    stall = 0;
    drive(0, 8'h00, 0, 0);
    @(negedge sim_clk);
    rst_n = 1'b1;
    @(posedge sim_clk);
    #1;
    drive(1, 8'h5A, 0, 0); cycle();
    drive(0, 8'h00, 0, 0); cycle(); cycle();
    check("t6_post_rst_valid", rd_valid, 1);
    check("t6_post_rst_data", rd_data, 8'h5A);
    drive(0, 8'h00, 1, 0); cycle();

    // Randomized traffic with occasional flush
    repeat (400) begin
      drive(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, ($urandom % 50) == 0);
      cycle();
    end
    drive(0, 8'h00, 1, 0);
    repeat (8) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
